// File: rtl/sp_tracker.sv
// sp_tracker: two-axis sweep/track sun tracker; START/TRACK_EN/V_IN/V_VALID in, SOC, servo indices H_POS/V_POS, MAX_V, STAT, DONE out
module sp_tracker #(
  parameter int ADC_W = 12,
  parameter int H_STEPS = 16,
  parameter int V_STEPS = 8,
  parameter int SETTLE = 100,
  parameter int TRACK_PERIOD = 1000,
  localparam int HW = $clog2(H_STEPS),
  localparam int VW = $clog2(V_STEPS)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             TRACK_EN,
  input  logic [ADC_W-1:0] V_IN,
  input  logic             V_VALID,
  output logic             SOC,
  output logic [HW-1:0]    H_POS,
  output logic [VW-1:0]    V_POS,
  output logic [ADC_W-1:0] MAX_V,
  output logic [2:0]       STAT,
  output logic             DONE
);
  localparam int CMAX = SETTLE > TRACK_PERIOD ? SETTLE : TRACK_PERIOD;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] S_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] T_LAST = CW'(TRACK_PERIOD - 1);
  localparam logic [HW-1:0] H_LAST = HW'(H_STEPS - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_STEPS - 1);
  typedef enum logic [2:0] {IDLE = 3'd0, H_SWEEP = 3'd1, V_SWEEP = 3'd2, PARK = 3'd3, HOLD = 3'd4, TRACK = 3'd5} state_t;
  typedef enum logic [2:0] {M_SETTLE, M_SOC, M_WAIT, M_NEXT, M_MOVE} ph_t;
  state_t state, state_n;
  ph_t ph, ph_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [HW-1:0] best_h, bh_n, h_n, nh;
  logic [VW-1:0] best_v, bv_n, v_n, nv;
  logic [ADC_W-1:0] max_n;
  logic [2:0] k, k_n, nk;
  logic [4:0] vld, avail;
  logic go, measuring;
  assign go = (state == IDLE || state == HOLD) && START;
  assign measuring = state == H_SWEEP || state == V_SWEEP || state == TRACK;
  assign SOC = measuring && ph == M_SOC;
  assign STAT = state;
  assign DONE = state == PARK;
  assign vld = {best_v != '0, best_v != V_LAST, best_h != '0, best_h != H_LAST, 1'b0};
  assign avail = vld & ~((5'd2 << k) - 5'd1);
  assign nk = avail[1] ? 3'd1 : avail[2] ? 3'd2 : avail[3] ? 3'd3 : avail[4] ? 3'd4 : 3'd0;
  assign nh = nk == 3'd1 ? best_h + 1'b1 : nk == 3'd2 ? best_h - 1'b1 : best_h;
  assign nv = nk == 3'd3 ? best_v + 1'b1 : nk == 3'd4 ? best_v - 1'b1 : best_v;
  always_comb begin
    state_n = state;
    ph_n = ph;
    cnt_n = cnt;
    h_n = H_POS;
    v_n = V_POS;
    max_n = MAX_V;
    bh_n = best_h;
    bv_n = best_v;
    k_n = k;
    if (go) begin
      state_n = H_SWEEP;
      ph_n = M_SETTLE;
      cnt_n = '0;
      h_n = '0;
      max_n = '0;
      bh_n = '0;
      bv_n = V_POS;
    end else if (state == PARK) begin
      state_n = TRACK_EN ? HOLD : IDLE;
      cnt_n = '0;
    end else if (state == HOLD) begin
      state_n = !TRACK_EN ? IDLE : cnt == T_LAST ? TRACK : HOLD;
      cnt_n = cnt == T_LAST ? '0 : cnt + 1'b1;
      ph_n = M_SETTLE;
      k_n = '0;
    end else if (measuring) begin
      unique case (ph)
        M_SETTLE: begin
          ph_n = cnt == S_LAST ? M_SOC : M_SETTLE;
          cnt_n = cnt == S_LAST ? '0 : cnt + 1'b1;
        end
        M_SOC: ph_n = M_WAIT;
        M_WAIT: if (V_VALID) begin
          ph_n = M_NEXT;
          if (state == TRACK && k == '0) max_n = V_IN;
          else if (V_IN > MAX_V) begin
            max_n = V_IN;
            bh_n = H_POS;
            bv_n = V_POS;
          end
        end
        M_NEXT: begin
          ph_n = M_SETTLE;
          if (state == TRACK) begin
            h_n = best_h;
            v_n = best_v;
            ph_n = M_MOVE;
          end else if (state == H_SWEEP) begin
            h_n = H_POS == H_LAST ? best_h : H_POS + 1'b1;
            v_n = H_POS == H_LAST ? '0 : V_POS;
            state_n = H_POS == H_LAST ? V_SWEEP : H_SWEEP;
          end else begin
            v_n = V_POS == V_LAST ? best_v : V_POS + 1'b1;
            state_n = V_POS == V_LAST ? PARK : V_SWEEP;
          end
        end
        default: begin
          ph_n = M_SETTLE;
          h_n = nh;
          v_n = nv;
          k_n = nk;
          state_n = nk == '0 ? HOLD : TRACK;
          cnt_n = '0;
        end
      endcase
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      ph <= M_SETTLE;
      cnt <= '0;
      H_POS <= '0;
      V_POS <= '0;
      MAX_V <= '0;
      best_h <= '0;
      best_v <= '0;
      k <= '0;
    end else begin
      state <= state_n;
      ph <= ph_n;
      cnt <= cnt_n;
      H_POS <= h_n;
      V_POS <= v_n;
      MAX_V <= max_n;
      best_h <= bh_n;
      best_v <= bv_n;
      k <= k_n;
    end
  end
endmodule

// File: tb/tb_sp_tracker.sv
// tb_sp_tracker: directed checks of sweep, tie, handshake, track, reset and hold control
module tb_sp_tracker;
  localparam int ADC_W = 12;
  localparam int H_STEPS = 16;
  localparam int V_STEPS = 8;
  localparam int SETTLE = 3;
  localparam int TRACK_PERIOD = 10;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic START = 1'b0;
  logic TRACK_EN = 1'b0;
  logic V_VALID = 1'b0;
  logic [ADC_W-1:0] V_IN = '0;
  logic SOC, DONE;
  logic [3:0] H_POS;
  logic [2:0] V_POS;
  logic [ADC_W-1:0] MAX_V;
  logic [2:0] STAT;
  int checks = 0;
  int errors = 0;
  int soc_cnt = 0;
  int done_cnt = 0;
  int mode = 0;
  int lat = 1;
  bit junk = 1'b0;
  sp_tracker #(.ADC_W(ADC_W), .H_STEPS(H_STEPS), .V_STEPS(V_STEPS), .SETTLE(SETTLE), .TRACK_PERIOD(TRACK_PERIOD)) dut (
    .CLK(CLK), .RST(RST), .START(START), .TRACK_EN(TRACK_EN), .V_IN(V_IN), .V_VALID(V_VALID),
    .SOC(SOC), .H_POS(H_POS), .V_POS(V_POS), .MAX_V(MAX_V), .STAT(STAT), .DONE(DONE)
  );
  always #5 CLK = ~CLK;
  function automatic int model(int h, int v);
    if (mode == 0) return 100 + (h == 5 ? 10 : 0) + (h == 5 && v == 2 ? 5 : 0);
    if (mode == 1) return (h == 3 || h == 9) ? 200 : 50;
    if (mode == 2) return 100 + (h == 15 ? 20 : 0) + (v == 7 ? 20 : 0);
    return 100 + (h == 14 ? 30 : 0) + (v == 7 ? 20 : 0);
  endfunction
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic wait_stat(input int s, input int budget);
    int n = 0;
    while (int'(STAT) != s && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (int'(STAT) != s) check("stat_timeout", STAT, s);
  endtask
  task automatic pulse_start();
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask
  initial forever begin
    @(negedge CLK);
    if (SOC) begin
      V_VALID = junk;
      V_IN = junk ? 12'd4000 : 12'd0;
      repeat (lat - 1) begin
        @(negedge CLK);
        V_VALID = 1'b0;
      end
      @(negedge CLK);
      V_VALID = 1'b1;
      V_IN = ADC_W'(model(int'(H_POS), int'(V_POS)));
      @(negedge CLK);
      V_VALID = 1'b0;
    end else begin
      V_VALID = junk;
      V_IN = junk ? 12'd4000 : 12'd0;
    end
  end
  always @(negedge CLK) begin
    if (SOC) soc_cnt++;
    if (DONE) done_cnt++;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge CLK);
    check("rst_soc", SOC, 0);
    check("rst_h", H_POS, 0);
    check("rst_v", V_POS, 0);
    check("rst_max", MAX_V, 0);
    check("rst_stat", STAT, 0);
    check("rst_done", DONE, 0);
    RST = 1'b0;
    @(negedge CLK);
    mode = 0; junk = 1'b1; lat = 1; soc_cnt = 0; done_cnt = 0;
    pulse_start();
    check("start_stat", STAT, 1);
    check("start_h", H_POS, 0);
    wait_stat(2, 400);
    check("hs_h", H_POS, 5);
    check("hs_v", V_POS, 0);
    check("hs_max", MAX_V, 110);
    wait_stat(0, 400);
    check("sw_done_cnt", done_cnt, 1);
    check("sw_soc_cnt", soc_cnt, 24);
    check("sw_h", H_POS, 5);
    check("sw_v", V_POS, 2);
    check("sw_max", MAX_V, 115);
    mode = 1; junk = 1'b0; lat = 50; soc_cnt = 0;
    pulse_start();
    begin
      int n = 0;
      while (!SOC && n < 20) begin
        @(negedge CLK);
        n++;
      end
    end
    check("stall_soc_seen", SOC, 1);
    repeat (45) @(negedge CLK);
    check("stall_h", H_POS, 0);
    check("stall_soc_cnt", soc_cnt, 1);
    check("stall_stat", STAT, 1);
    wait_stat(0, 3000);
    check("tie_h", H_POS, 3);
    check("tie_v", V_POS, 2);
    check("tie_max", MAX_V, 200);
    mode = 2; lat = 1; TRACK_EN = 1'b1;
    pulse_start();
    wait_stat(4, 400);
    check("park_h", H_POS, 15);
    check("park_v", V_POS, 7);
    check("park_max", MAX_V, 140);
    mode = 3; soc_cnt = 0;
    wait_stat(5, 40);
    check("track_stat", STAT, 5);
    wait_stat(4, 200);
    check("track_h", H_POS, 14);
    check("track_v", V_POS, 7);
    check("track_max", MAX_V, 150);
    check("track_soc_cnt", soc_cnt, 3);
    TRACK_EN = 1'b0;
    @(negedge CLK);
    check("hold_off_stat", STAT, 0);
    check("hold_off_h", H_POS, 14);
    check("hold_off_v", V_POS, 7);
    TRACK_EN = 1'b1;
    pulse_start();
    wait_stat(4, 400);
    check("hold2_max", MAX_V, 150);
    pulse_start();
    check("hold_start_stat", STAT, 1);
    check("hold_start_h", H_POS, 0);
    begin
      int n = 0;
      while (!(STAT == 3'd2 && SOC) && n < 400) begin
        @(negedge CLK);
        n++;
      end
    end
    check("vsoc_found", SOC, 1);
    RST = 1'b1;
    @(negedge CLK);
    check("mid_rst_soc", SOC, 0);
    check("mid_rst_h", H_POS, 0);
    check("mid_rst_v", V_POS, 0);
    check("mid_rst_max", MAX_V, 0);
    check("mid_rst_stat", STAT, 0);
    check("mid_rst_done", DONE, 0);
    RST = 1'b0;
    TRACK_EN = 1'b0;
    mode = 0;
    pulse_start();
    check("re_start_stat", STAT, 1);
    wait_stat(0, 400);
    check("re_h", H_POS, 5);
    check("re_v", V_POS, 2);
    check("re_max", MAX_V, 115);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
